// File: rtl/uart_matrix_loader.sv
// Frame parser for the UART byte stream: SYNC, CMD (A/B select), then N*N payload bytes
// assembled row-major into operand matrix A or B; raises compute_start once both are held.
module uart_matrix_loader #(
  parameter int          N              = 2,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 1_000_000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [7:0]         rx_data,
  input  logic               rx_done,
  input  logic               ack_clear,
  output logic [8*N*N-1:0]   matrix_a,
  output logic [8*N*N-1:0]   matrix_b,
  output logic               a_valid,
  output logic               b_valid,
  output logic               load_done,
  output logic               compute_start,
  output logic               frame_err,
  output logic               busy
);

  localparam int NE = N * N;
  localparam int CW = $clog2(NE) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] E_LAST = CW'(NE - 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, CMD, PAYLOAD} state_t;

  state_t            state_q, state_d;
  logic              tgt_q, tgt_d;
  logic [CW-1:0]     elem_cnt_q, elem_cnt_d;
  logic [TW-1:0]     tmo_q, tmo_d;
  logic [8*NE-1:0]   mat_a_q, mat_a_d, mat_b_q, mat_b_d;
  logic              a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic              load_done_q, load_done_d;
  logic              compute_start_q, compute_start_d;
  logic              frame_err_q, frame_err_d;

  always_comb begin
    state_d         = state_q;
    tgt_d           = tgt_q;
    elem_cnt_d      = elem_cnt_q;
    tmo_d           = tmo_q;
    mat_a_d         = mat_a_q;
    mat_b_d         = mat_b_q;
    a_valid_d       = a_valid_q;
    b_valid_d       = b_valid_q;
    load_done_d     = 1'b0;
    compute_start_d = 1'b0;
    frame_err_d     = 1'b0;

    // Clear first so a completion in the same cycle can re-set its own flag.
    if (ack_clear) begin
      a_valid_d = 1'b0;
      b_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        tmo_d = '0;
        if (rx_done && rx_data == SYNC_BYTE) state_d = CMD;
      end
      CMD: begin
        if (rx_done) begin
          tmo_d = '0;
          if (rx_data == 8'h00 || rx_data == 8'h01) begin
            tgt_d      = rx_data[0];
            elem_cnt_d = '0;
            state_d    = PAYLOAD;
            if (rx_data[0]) b_valid_d = 1'b0;
            else            a_valid_d = 1'b0;
          end else begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
          end
        end else if (tmo_q == T_LAST) begin
          frame_err_d = 1'b1;
          tmo_d       = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      PAYLOAD: begin
        if (rx_done) begin
          tmo_d      = '0;
          elem_cnt_d = elem_cnt_q + CW'(1);
          for (int k = 0; k < NE; k++) begin
            if (elem_cnt_q == CW'(k)) begin
              if (tgt_q) mat_b_d[8*k +: 8] = rx_data;
              else       mat_a_d[8*k +: 8] = rx_data;
            end
          end
          if (elem_cnt_q == E_LAST) begin
            load_done_d = 1'b1;
            state_d     = IDLE;
            // The other operand's flag is judged before any coincident ack_clear.
            if (tgt_q) begin
              b_valid_d       = 1'b1;
              compute_start_d = a_valid_q;
            end else begin
              a_valid_d       = 1'b1;
              compute_start_d = b_valid_q;
            end
          end
        end else if (tmo_q == T_LAST) begin
          frame_err_d = 1'b1;
          tmo_d       = '0;
          state_d     = IDLE;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q         <= IDLE;
      tgt_q           <= 1'b0;
      elem_cnt_q      <= '0;
      tmo_q           <= '0;
      mat_a_q         <= '0;
      mat_b_q         <= '0;
      a_valid_q       <= 1'b0;
      b_valid_q       <= 1'b0;
      load_done_q     <= 1'b0;
      compute_start_q <= 1'b0;
      frame_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      tgt_q           <= tgt_d;
      elem_cnt_q      <= elem_cnt_d;
      tmo_q           <= tmo_d;
      mat_a_q         <= mat_a_d;
      mat_b_q         <= mat_b_d;
      a_valid_q       <= a_valid_d;
      b_valid_q       <= b_valid_d;
      load_done_q     <= load_done_d;
      compute_start_q <= compute_start_d;
      frame_err_q     <= frame_err_d;
    end
  end

  assign matrix_a      = mat_a_q;
  assign matrix_b      = mat_b_q;
  assign a_valid       = a_valid_q;
  assign b_valid       = b_valid_q;
  assign load_done     = load_done_q;
  assign compute_start = compute_start_q;
  assign frame_err     = frame_err_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_uart_matrix_loader.sv
// Bench for uart_matrix_loader: directed vector table, hand-built timeout/reset sequences,
// and a random byte stream, all compared every cycle against a frame-level reference model.
module tb_uart_matrix_loader;
  localparam int         N    = 2;
  localparam int         NE   = N * N;
  localparam int         T    = 50;
  localparam logic [7:0] SYNC = 8'hA5;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [7:0]      rx_data = 8'h00;
  logic            rx_done = 1'b0;
  logic            ack_clear = 1'b0;
  logic [8*NE-1:0] matrix_a, matrix_b;
  logic            a_valid, b_valid, load_done, compute_start, frame_err, busy;

  int vectors = 0;
  int miscompares = 0;

  uart_matrix_loader #(.N(N), .SYNC_BYTE(SYNC), .TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done(rx_done), .ack_clear(ack_clear),
    .matrix_a(matrix_a), .matrix_b(matrix_b), .a_valid(a_valid), .b_valid(b_valid),
    .load_done(load_done), .compute_start(compute_start), .frame_err(frame_err), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference model: pos = -1 outside a frame, 0 awaiting command, k>0 awaiting payload byte k.
  int              m_pos, m_quiet;
  logic            m_tgt;
  logic [8*NE-1:0] m_ma, m_mb;
  logic            m_av, m_bv, m_ld, m_cs, m_fe;

  task automatic model_reset();
    m_pos = -1; m_quiet = 0; m_tgt = 1'b0;
    m_ma = '0; m_mb = '0;
    m_av = 1'b0; m_bv = 1'b0; m_ld = 1'b0; m_cs = 1'b0; m_fe = 1'b0;
  endtask

  task automatic model_step(input logic rx, input logic [7:0] d, input logic ack);
    logic av0, bv0;
    av0 = m_av; bv0 = m_bv;
    m_ld = 1'b0; m_cs = 1'b0; m_fe = 1'b0;
    if (ack) begin m_av = 1'b0; m_bv = 1'b0; end
    if (!rx) begin
      if (m_pos >= 0) begin
        m_quiet++;
        if (m_quiet == T) begin m_fe = 1'b1; m_pos = -1; m_quiet = 0; end
      end
    end else begin
      m_quiet = 0;
      if (m_pos < 0) begin
        if (d == SYNC) m_pos = 0;
      end else if (m_pos == 0) begin
        if (d == 8'h00 || d == 8'h01) begin
          m_tgt = d[0];
          if (m_tgt) m_bv = 1'b0; else m_av = 1'b0;
          m_pos = 1;
        end else begin
          m_fe = 1'b1; m_pos = -1;
        end
      end else begin
        if (m_tgt) m_mb[8*(m_pos-1) +: 8] = d; else m_ma[8*(m_pos-1) +: 8] = d;
        if (m_pos == NE) begin
          m_ld = 1'b1;
          if (m_tgt) begin m_bv = 1'b1; m_cs = av0; end
          else       begin m_av = 1'b1; m_cs = bv0; end
          m_pos = -1;
        end else begin
          m_pos++;
        end
      end
    end
  endtask

  task automatic check_model(input string tag);
    logic m_busy;
    m_busy = (m_pos >= 0);
    vectors++;
    if (matrix_a !== m_ma || matrix_b !== m_mb || a_valid !== m_av || b_valid !== m_bv ||
        load_done !== m_ld || compute_start !== m_cs || frame_err !== m_fe || busy !== m_busy) begin
      miscompares++;
      $display("FAIL %s t=%0t got a=%h b=%h av=%b bv=%b ld=%b cs=%b fe=%b busy=%b want a=%h b=%h av=%b bv=%b ld=%b cs=%b fe=%b busy=%b",
               tag, $time, matrix_a, matrix_b, a_valid, b_valid, load_done, compute_start, frame_err, busy,
               m_ma, m_mb, m_av, m_bv, m_ld, m_cs, m_fe, m_busy);
    end
  endtask

  task automatic expect_eq(input string tag, input longint act, input longint exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic cycle(input logic rx, input logic [7:0] d, input logic ack);
    rx_done = rx; rx_data = d; ack_clear = ack;
    model_step(rx, d, ack);
    @(posedge clk); #1;
    rx_done = 1'b0; ack_clear = 1'b0;
    check_model("model");
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'($urandom), 1'b0);
  endtask

  typedef struct {
    logic rx; logic [7:0] data; logic ack;
    logic av, bv, ld, cs, fe, bsy;
    logic chk; logic [31:0] ma, mb;
  } vec_t;

  function automatic vec_t mk(input logic rx, input logic [7:0] data, input logic ack,
                              input logic [5:0] flags, input logic chk,
                              input logic [31:0] ma, input logic [31:0] mb);
    vec_t v;
    v.rx = rx; v.data = data; v.ack = ack;
    {v.av, v.bv, v.ld, v.cs, v.fe, v.bsy} = flags;
    v.chk = chk; v.ma = ma; v.mb = mb;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    int err_at;
    logic err_seen;
    logic [7:0] d;
    int gap, r;

    model_reset();
    // flags = {a_valid, b_valid, load_done, compute_start, frame_err, busy}
    tbl.push_back(mk(1, 8'hA5, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h03, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h04, 0, 6'b101000, 1, 32'h04030201, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h10, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h20, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h30, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h40, 0, 6'b111100, 1, 32'h04030201, 32'h40302010));
    tbl.push_back(mk(0, 8'h00, 1, 6'b000000, 1, 32'h04030201, 32'h40302010));
    tbl.push_back(mk(1, 8'h7E, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(1, 8'h33, 0, 6'b000000, 0, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h05, 0, 6'b000010, 0, 0, 0));
    tbl.push_back(mk(1, 8'hA5, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h00, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h55, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h66, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h77, 0, 6'b000001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h88, 0, 6'b101000, 1, 32'h88776655, 32'h40302010));
    // last B byte coincides with ack_clear while A is valid
    tbl.push_back(mk(1, 8'hA5, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'h01, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'hB1, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'hB2, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'hB3, 0, 6'b100001, 0, 0, 0));
    tbl.push_back(mk(1, 8'hB4, 1, 6'b011100, 1, 32'h88776655, 32'hB4B3B2B1));

    repeat (2) @(posedge clk);
    #1;
    check_model("reset_state");
    expect_eq("reset_outputs", {matrix_a, matrix_b, a_valid, b_valid, load_done,
                                compute_start, frame_err, busy}, 0);
    reset = 1'b0;

    foreach (tbl[i]) begin
      idle(2);
      cycle(tbl[i].rx, tbl[i].data, tbl[i].ack);
      vectors++;
      if ({a_valid, b_valid, load_done, compute_start, frame_err, busy} !==
          {tbl[i].av, tbl[i].bv, tbl[i].ld, tbl[i].cs, tbl[i].fe, tbl[i].bsy} ||
          (tbl[i].chk && (matrix_a !== tbl[i].ma || matrix_b !== tbl[i].mb))) begin
        miscompares++;
        $display("FAIL table[%0d] got flags=%b a=%h b=%h want flags=%b a=%h b=%h", i,
                 {a_valid, b_valid, load_done, compute_start, frame_err, busy}, matrix_a, matrix_b,
                 {tbl[i].av, tbl[i].bv, tbl[i].ld, tbl[i].cs, tbl[i].fe, tbl[i].bsy}, tbl[i].ma, tbl[i].mb);
      end
    end

    // Timeout after a partial frame.
    cycle(1, 8'hA5, 0); cycle(1, 8'h00, 0); cycle(1, 8'h11, 0);
    err_at = -1;
    for (int k = 1; k <= 60; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      if (frame_err && err_at < 0) err_at = k;
    end
    expect_eq("timeout_latency", err_at, T);
    expect_eq("timeout_a_valid", a_valid, 0);
    expect_eq("timeout_busy", busy, 0);

    // Byte arriving exactly on the expiry cycle is accepted.
    err_seen = 1'b0;
    cycle(1, 8'hA5, 0); cycle(1, 8'h00, 0);
    for (int k = 0; k < T - 1; k++) begin
      cycle(1'b0, 8'h00, 1'b0);
      err_seen |= frame_err;
    end
    cycle(1, 8'h22, 0); err_seen |= frame_err;
    expect_eq("expiry_busy", busy, 1);
    cycle(1, 8'h33, 0); err_seen |= frame_err;
    cycle(1, 8'h44, 0); err_seen |= frame_err;
    cycle(1, 8'h55, 0); err_seen |= frame_err;
    idle(1); err_seen |= frame_err;
    expect_eq("expiry_no_err", err_seen, 0);
    expect_eq("expiry_a_valid", a_valid, 1);
    expect_eq("expiry_matrix_a", matrix_a, 32'h55443322);

    // Asynchronous reset mid-payload, between clock edges.
    cycle(1, 8'hA5, 0); cycle(1, 8'h01, 0); cycle(1, 8'hDE, 0); cycle(1, 8'hAD, 0);
    expect_eq("pre_reset_busy", busy, 1);
    reset = 1'b1;
    #2;
    expect_eq("async_reset_outputs", {matrix_a, matrix_b, a_valid, b_valid, load_done,
                                      compute_start, frame_err, busy}, 0);
    model_reset();
    #2;
    reset = 1'b0;
    cycle(1, 8'hA5, 0); cycle(1, 8'h01, 0);
    cycle(1, 8'h01, 0); cycle(1, 8'h02, 0); cycle(1, 8'h03, 0); cycle(1, 8'h04, 0);
    expect_eq("post_reset_matrix_b", matrix_b, 32'h04030201);
    expect_eq("post_reset_b_valid", b_valid, 1);

    // Random byte stream with occasional acks and gaps at the timeout boundary.
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 19);
      gap = (r == 0) ? T - 1 : (r == 1) ? T : $urandom_range(0, 3);
      for (int g = 0; g < gap; g++)
        cycle(1'b0, 8'($urandom), ($urandom_range(0, 15) == 0));
      r = $urandom_range(0, 9);
      d = (r < 3) ? SYNC : (r < 5) ? 8'h00 : (r == 5) ? 8'h01 : (r == 6) ? 8'h05 : 8'($urandom);
      cycle(1'b1, d, ($urandom_range(0, 15) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
